serial_adder: RTL
=================

# serial_adder

Bit-serial adder built around the one-bit full adder cell: it captures two WIDTH-bit operands plus a carry-in, then adds them LSB-first, one bit per clock, through a single full adder and a carry flip-flop. It trades latency for area. It is the sequential consumer of the combinational full adder stage. It presents a start/busy/done handshake to upstream control logic and holds a registered result for downstream logic.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only when the block is not busy.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while serial bits are being processed.
- done  output  1  one-cycle pulse indicating that sum/cout hold a new result.
- sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
- cout  output  1  registered carry out of the MSB.
- ovf  output  1  signed overflow. Present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states:
  - IDLE: start=1 loads the A/B shift registers and carry←cin, clears the bit counter, and moves to SHIFT.
  - SHIFT: each cycle computes full_adder(a_sr[0], b_sr[0], carry) and does the following:
    - the sum bit shifts into the MSB of the accumulator, with the accumulator shifting right;
    - a_sr and b_sr shift right;
    - carry takes the adder carry;
    - the counter increments.
  - SHIFT exits to DONE when the counter reaches WIDTH-1.
  - DONE: done=1 for exactly this cycle; sum/cout/ovf were loaded on entry. start=1 here is accepted exactly as in IDLE and goes straight to SHIFT. Otherwise the FSM returns to IDLE.
- start while busy=1 is ignored; there is no queueing. a/b/cin may change freely after acceptance.
- sum/cout/ovf update only on entry to DONE. They hold their value through IDLE and through subsequent operations until the next completion.
- Arithmetic: unsigned; {cout,sum} = a + b + cin, exactly WIDTH+1 bits.
- Counter width: $clog2(WIDTH); counts 0..WIDTH-1 with no wrap beyond that.
- Reset (any time, including mid-SHIFT):
  - FSM goes to IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Shift registers, carry and counter are cleared.
  - The partial operation is discarded. The first start after rst_n deasserts is accepted normally.

## Timing
- Accepting start at edge T0 gives the following sequence:
  - busy=1 during cycles T0+1 .. T0+WIDTH;
  - done=1 and new sum/cout valid in cycle T0+WIDTH+1;
  - busy=0 in the done cycle.
- Latency from start to done is WIDTH+1 cycles. Back-to-back throughput is one result per WIDTH+1 cycles, because start is accepted during the done cycle.
- busy and done are never high simultaneously. All outputs are registered, with no combinational path from inputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - port ovf exists;
  - the carry into the MSB is captured during the final SHIFT cycle;
  - on entry to DONE, ovf = carry_into_msb XOR cout.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

## Structure
- Package serial_adder_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE), 2 bits;
  - the WIDTH range limits as constants.
- One sub-module: full_adder_gate (ports a, b, c, sum, carry). It is instantiated once as the serial bit-slice. All sequential logic lives in serial_adder.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, cin=0, start pulse → busy for 8 cycles; done in cycle 9; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1. a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- start held high continuously with changing a/b → the second operation uses operands present at the done-cycle edge; start during busy is ignored; results arrive every 9 cycles.
- rst_n asserted in the 4th SHIFT cycle → busy, done, sum and cout go to 0 immediately. After release, 0x12+0x34 gives sum=0x46 with full 9-cycle latency.
- Previous result 0x46 is held unchanged while busy during the next operation, and is replaced only at its done.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/full_adder_gate.sv
// One-bit full adder cell used as the serial bit-slice.
module full_adder_gate (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   logic ab_x;

   assign ab_x  = a ^ b;
   assign sum   = ab_x ^ c;
   assign carry = (a & b) | (c & ab_x);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder plus carry flop, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned ACC_W = WIDTH - 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fa_sum, fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_adder_gate u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // Next state, datapath updates and registered-output next values
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = SHIFT;
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = fa_carry;
            // Accumulator keeps the low WIDTH-1 sum bits; the last bit comes straight from the cell
            acc_d   = ACC_W'({fa_sum, acc_q} >> 1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               sum_d   = {fa_sum, acc_q};
               cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ fa_carry;
`endif
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               busy_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
